// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_pkg
// Description : Shared types and helpers for the LLC <-> burst memory adapter.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package mem_bus_pkg;

    // Adapter transaction state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } bus_state_t;

    // Beat index inside the line addressed by addr: bits [off+iw-1:off].
    // Returned as 8 bits; callers size-cast down to their own index width.
    function automatic logic [7:0] beat_index(input logic [63:0] addr,
                                              input int unsigned off,
                                              input int unsigned iw);
        logic [63:0] shifted;
        logic [63:0] mask;
        shifted = addr >> off;
        mask    = (64'd1 << iw) - 64'd1;
        return 8'(shifted & mask);
    endfunction

endpackage : mem_bus_pkg
`default_nettype wire

// File: rtl/burst_beat_seq.sv
`default_nettype none
// ============================================================================
// Module      : burst_beat_seq
// Description : Wrapping beat index plus beats-remaining counter shared by the
//               read and write paths of burst_line_adapter.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module burst_beat_seq #(
    parameter int BEATS = 4,
    parameter int IW    = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [IW-1:0] start,
    input  logic          advance,
    output logic [IW-1:0] index,
    output logic          first,
    output logic          last
);

    localparam logic [IW:0] C_BEATS = (IW + 1)'(BEATS);

    logic [IW:0] beats_left;

    // Load a fresh transfer, or step one beat; the index wraps modulo BEATS
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            index      <= '0;
            beats_left <= '0;
        end else if (load) begin
            index      <= start;
            beats_left <= C_BEATS;
        end else if (advance && (beats_left != '0)) begin
            index      <= index + 1'b1;
            beats_left <= beats_left - 1'b1;
        end
    end

    assign first = (beats_left == C_BEATS);
    assign last  = (beats_left == (IW + 1)'(1));

endmodule : burst_beat_seq
`default_nettype wire

// File: rtl/burst_line_adapter.sv
`default_nettype none
// ============================================================================
// Module      : burst_line_adapter
// Description : Converts one cache-line read/write into BEATS memory beats,
//               with beat-level stalls and optional critical-word-first reads.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module burst_line_adapter
    import mem_bus_pkg::*;
#(
    parameter int LINE_BITS  = 256,
    parameter int BURST_BITS = 64,
    parameter int ADDR_W     = 32,
    parameter int WRAP_READ  = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [LINE_BITS-1:0]  line_i,
    output logic [LINE_BITS-1:0]  line_o,
    input  logic [ADDR_W-1:0]     address_i,
    input  logic                  read_i,
    input  logic                  write_i,
    output logic                  resp_o,
    output logic                  crit_valid_o,
    output logic [BURST_BITS-1:0] crit_word_o,
    input  logic [BURST_BITS-1:0] burst_i,
    output logic [BURST_BITS-1:0] burst_o,
    output logic [ADDR_W-1:0]     address_o,
    output logic                  read_o,
    output logic                  write_o,
    input  logic                  resp_i
);

    localparam int BEATS = LINE_BITS / BURST_BITS;
    localparam int IW    = $clog2(BEATS);
    localparam int OFF   = $clog2(BURST_BITS / 8);

    // Masks clearing the in-line offset (line aligned) or only the in-beat
    // offset (beat aligned, used for wrapping reads)
    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << (OFF + IW)) - ADDR_W'(1));
    localparam logic [ADDR_W-1:0] BEAT_MASK = ~((ADDR_W'(1) << OFF) - ADDR_W'(1));

    bus_state_t state;

    logic [BEATS-1:0][BURST_BITS-1:0] linebuf;
    logic [ADDR_W-1:0]                addr_q;

    logic [IW-1:0] crit;
    logic [IW-1:0] start_index;
    logic [IW-1:0] index;
    logic          seq_load;
    logic          seq_advance;
    logic          seq_first;
    logic          seq_last;
    logic          in_xfer;
    logic [ADDR_W-1:0] addr_next;

    assign crit        = IW'(beat_index(64'(address_i), OFF, IW));
    assign seq_load    = (state == IDLE) && (read_i || write_i);
    assign start_index = (read_i && (WRAP_READ != 0)) ? crit : '0;
    assign in_xfer     = (state == RD) || (state == WR);
    assign seq_advance = in_xfer && resp_i;

    // A wrapping read points the memory at the critical beat; otherwise the line base
    assign addr_next = (read_i && (WRAP_READ != 0)) ? (address_i & BEAT_MASK)
                                                    : (address_i & LINE_MASK);

    burst_beat_seq #(
        .BEATS (BEATS),
        .IW    (IW)
    ) u_seq (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (seq_load),
        .start   (start_index),
        .advance (seq_advance),
        .index   (index),
        .first   (seq_first),
        .last    (seq_last)
    );

    // Transaction FSM: owns state, line buffer, address register and command outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            linebuf <= '0;
            addr_q  <= '0;
            read_o  <= 1'b0;
            write_o <= 1'b0;
            resp_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (read_i) begin
                        state   <= RD;
                        addr_q  <= addr_next;
                        read_o  <= 1'b1;
                    end else if (write_i) begin
                        state   <= WR;
                        addr_q  <= addr_next;
                        linebuf <= line_i;
                        write_o <= 1'b1;
                    end
                end
                RD: begin
                    if (resp_i) begin
                        linebuf[index] <= burst_i;
                        if (seq_last) begin
                            state  <= DONE;
                            read_o <= 1'b0;
                            resp_o <= 1'b1;
                        end
                    end
                end
                WR: begin
                    if (resp_i && seq_last) begin
                        state   <= DONE;
                        write_o <= 1'b0;
                        resp_o  <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    resp_o <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Early-restart: the first accepted read beat is passed straight through
    assign crit_valid_o = (state == RD) && resp_i && seq_first;
    assign crit_word_o  = crit_valid_o ? burst_i : '0;

    assign burst_o   = (state == WR) ? linebuf[index] : '0;
    assign line_o    = resp_o ? linebuf : '0;
    assign address_o = addr_q;

endmodule : burst_line_adapter
`default_nettype wire

// File: tb/tb_burst_line_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_burst_line_adapter
// Description : Directed self-checking bench for burst_line_adapter
//               (linear, wrapped, stalled write, priority, reset, 16-beat).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_burst_line_adapter;

    logic clk = 1'b0;
    logic reset_n;

    // Shared stimulus for the two 256/64 instances
    logic [255:0] line_ab;
    logic [31:0]  addr_ab;
    logic [63:0]  burst_in_ab;
    logic         resp_in_ab;
    logic         read_a, write_a, read_b, write_b;

    // Instance A: WRAP_READ = 0
    logic [255:0] line_o_a;
    logic         resp_o_a, crit_valid_a, read_o_a, write_o_a;
    logic [63:0]  crit_word_a, burst_o_a;
    logic [31:0]  address_o_a;

    // Instance B: WRAP_READ = 1
    logic [255:0] line_o_b;
    logic         resp_o_b, crit_valid_b, read_o_b, write_o_b;
    logic [63:0]  crit_word_b, burst_o_b;
    logic [31:0]  address_o_b;

    // Instance C: 512/32, WRAP_READ = 1
    logic [511:0] line_c, line_o_c;
    logic [31:0]  addr_c, burst_in_c, crit_word_c, burst_o_c, address_o_c;
    logic         read_c, write_c, resp_in_c;
    logic         resp_o_c, crit_valid_c, read_o_c, write_o_c;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    burst_line_adapter #(.LINE_BITS(256), .BURST_BITS(64), .ADDR_W(32), .WRAP_READ(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .line_i(line_ab), .line_o(line_o_a),
        .address_i(addr_ab), .read_i(read_a), .write_i(write_a), .resp_o(resp_o_a),
        .crit_valid_o(crit_valid_a), .crit_word_o(crit_word_a), .burst_i(burst_in_ab),
        .burst_o(burst_o_a), .address_o(address_o_a), .read_o(read_o_a),
        .write_o(write_o_a), .resp_i(resp_in_ab)
    );

    burst_line_adapter #(.LINE_BITS(256), .BURST_BITS(64), .ADDR_W(32), .WRAP_READ(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .line_i(line_ab), .line_o(line_o_b),
        .address_i(addr_ab), .read_i(read_b), .write_i(write_b), .resp_o(resp_o_b),
        .crit_valid_o(crit_valid_b), .crit_word_o(crit_word_b), .burst_i(burst_in_ab),
        .burst_o(burst_o_b), .address_o(address_o_b), .read_o(read_o_b),
        .write_o(write_o_b), .resp_i(resp_in_ab)
    );

    burst_line_adapter #(.LINE_BITS(512), .BURST_BITS(32), .ADDR_W(32), .WRAP_READ(1)) dut_c (
        .clk(clk), .reset_n(reset_n), .line_i(line_c), .line_o(line_o_c),
        .address_i(addr_c), .read_i(read_c), .write_i(write_c), .resp_o(resp_o_c),
        .crit_valid_o(crit_valid_c), .crit_word_o(crit_word_c), .burst_i(burst_in_c),
        .burst_o(burst_o_c), .address_o(address_o_c), .read_o(read_o_c),
        .write_o(write_o_c), .resp_i(resp_in_c)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] A = 64'hAAAA_0000_0000_0001;
    localparam logic [63:0] B = 64'hBBBB_0000_0000_0002;
    localparam logic [63:0] C = 64'hCCCC_0000_0000_0003;
    localparam logic [63:0] D = 64'hDDDD_0000_0000_0004;

    logic [63:0]  beats4 [4];
    logic [63:0]  wr_exp [6];
    logic         wr_resp [6];
    logic [511:0] exp_c;

    initial begin
        reset_n = 1'b0;
        line_ab = '0; addr_ab = '0; burst_in_ab = '0; resp_in_ab = 1'b0;
        read_a = 0; write_a = 0; read_b = 0; write_b = 0;
        line_c = '0; addr_c = '0; burst_in_c = '0; resp_in_c = 1'b0;
        read_c = 0; write_c = 0;
        step(); step();

        // ---------------- reset values
        check("rst_read_o",   read_o_a, 0);
        check("rst_write_o",  write_o_a, 0);
        check("rst_resp_o",   resp_o_a, 0);
        check("rst_crit_v",   crit_valid_a, 0);
        check("rst_line_o",   line_o_a, 0);
        check("rst_burst_o",  burst_o_a, 0);
        check("rst_addr_o",   address_o_a, 0);
        check("rst_crit_w",   crit_word_b, 0);
        reset_n = 1'b1;
        step();

        // ---------------- linear read on A
        beats4[0] = A; beats4[1] = B; beats4[2] = C; beats4[3] = D;
        addr_ab = 32'h1000_0048; read_a = 1'b1;
        step();                                     // edge N
        read_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            burst_in_ab = beats4[k]; resp_in_ab = 1'b1;
            #1;
            check("lin_read_o", read_o_a, 1);
            check("lin_addr_o", address_o_a, 32'h1000_0040);
            check("lin_crit_v", crit_valid_a, (k == 0));
            if (k == 0) check("lin_crit_w", crit_word_a, A);
            step();
        end
        resp_in_ab = 1'b0;                          // cycle N+5
        check("lin_resp_o", resp_o_a, 1);
        check("lin_line_o", line_o_a, {D, C, B, A});
        check("lin_read_lo", read_o_a, 0);
        step();
        check("lin_resp_end", resp_o_a, 0);

        // ---------------- wrapped read on B, crit = 2
        addr_ab = 32'h1000_0050; read_b = 1'b1;
        step();
        read_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            burst_in_ab = beats4[k]; resp_in_ab = 1'b1;  // W,X,Y,Z = A,B,C,D
            #1;
            check("wrp_addr_o", address_o_b, 32'h1000_0050);
            check("wrp_crit_v", crit_valid_b, (k == 0));
            if (k == 0) check("wrp_crit_w", crit_word_b, A);
            step();
        end
        resp_in_ab = 1'b0;
        check("wrp_resp_o", resp_o_b, 1);
        check("wrp_line_o", line_o_b, {B, A, D, C});
        step();

        // ---------------- stalled write on A
        wr_resp[0] = 1; wr_resp[1] = 0; wr_resp[2] = 0;
        wr_resp[3] = 1; wr_resp[4] = 1; wr_resp[5] = 1;
        wr_exp[0] = A; wr_exp[1] = B; wr_exp[2] = B;
        wr_exp[3] = B; wr_exp[4] = C; wr_exp[5] = D;
        line_ab = {D, C, B, A}; addr_ab = 32'h2000_0078; write_a = 1'b1;
        step();
        write_a = 1'b0; line_ab = '0;
        for (int k = 0; k < 6; k++) begin
            resp_in_ab = wr_resp[k];
            #1;
            check("wr_write_o", write_o_a, 1);
            check("wr_burst_o", burst_o_a, wr_exp[k]);
            check("wr_addr_o",  address_o_a, 32'h2000_0060);
            check("wr_resp_early", resp_o_a, 0);
            step();
        end
        resp_in_ab = 1'b0;
        check("wr_resp_o",  resp_o_a, 1);
        check("wr_write_lo", write_o_a, 0);
        step();

        // ---------------- read and write together: read wins
        addr_ab = 32'h1000_0000; read_a = 1'b1; write_a = 1'b1; line_ab = {4{C}};
        step();
        read_a = 1'b0; write_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            burst_in_ab = beats4[3 - k]; resp_in_ab = 1'b1;
            #1;
            check("pri_read_o",  read_o_a, 1);
            check("pri_write_o", write_o_a, 0);
            step();
        end
        resp_in_ab = 1'b0;
        check("pri_resp_o",  resp_o_a, 1);
        check("pri_write_lo", write_o_a, 0);
        check("pri_line_o",  line_o_a, {A, B, C, D});
        step();

        // ---------------- reset in the middle of a read on B, then clean read
        addr_ab = 32'h1000_0058; read_b = 1'b1;
        step();
        read_b = 1'b0;
        burst_in_ab = C; resp_in_ab = 1'b1;
        step();
        burst_in_ab = D;
        step();
        resp_in_ab = 1'b0; reset_n = 1'b0;
        step();
        check("mid_read_o", read_o_b, 0);
        check("mid_resp_o", resp_o_b, 0);
        check("mid_addr_o", address_o_b, 0);
        reset_n = 1'b1;
        addr_ab = 32'h1000_0048; read_b = 1'b1;     // crit = 1
        step();
        read_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            burst_in_ab = beats4[k]; resp_in_ab = 1'b1;
            #1;
            check("rr_addr_o", address_o_b, 32'h1000_0048);
            if (k == 0) check("rr_crit_w", crit_word_b, A);
            step();
        end
        resp_in_ab = 1'b0;
        check("rr_resp_o", resp_o_b, 1);
        check("rr_line_o", line_o_b, {C, B, A, D});
        step();

        // ---------------- 16-beat wrapped read on C from crit = 15
        for (int j = 0; j < 16; j++)
            exp_c[j*32 +: 32] = 32'hB000_0000 + 32'((j + 1) % 16);
        addr_c = 32'h2000_003C; read_c = 1'b1;
        step();                                     // edge N
        read_c = 1'b0;
        for (int k = 0; k < 16; k++) begin
            burst_in_c = 32'hB000_0000 + 32'(k); resp_in_c = 1'b1;
            #1;
            check("c_read_o", read_o_c, 1);
            check("c_resp_early", resp_o_c, 0);
            if (k == 0) check("c_addr_o", address_o_c, 32'h2000_003C);
            step();
        end
        resp_in_c = 1'b0;                           // cycle N+17
        check("c_resp_o", resp_o_c, 1);
        check("c_line_o", line_o_c, exp_c);
        step();
        check("c_resp_end", resp_o_c, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_burst_line_adapter
`default_nettype wire
